pwm_button_cfg_ctrl: RTL

//  Front-end controller for the button-driven PWM core. It synchronises and debounces the four

---
 rtl/pwm_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 76 +++++++
 rtl/pwm_button_cfg_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the button-driven PWM front end and the PWM core.
package pwm_pkg;

  // Default register widths, shared with the PWM core.
  localparam int DUTY_W_DEF = 8;
  localparam int DIV_W_DEF  = 8;

  // Button slots inside the per-button vectors of the controller.
  localparam int NUM_BTN      = 4;
  localparam int BTN_INC_DUTY = 0;
  localparam int BTN_DEC_DUTY = 1;
  localparam int BTN_INC_FREQ = 2;
  localparam int BTN_DEC_FREQ = 3;

  // Command chosen by the arbiter for the current cycle.
  // FREQ_UP lowers the divider, FREQ_DN raises it.
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_DUTY_UP,
    CMD_DUTY_DN,
    CMD_FREQ_UP,
    CMD_FREQ_DN
  } cmd_e;

  // Config handshake towards the PWM core.
  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, debounce counter, rising-edge event
// and hold-to-repeat timer. evt_o is a single-cycle pulse per step request.
module btn_debounce #(
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic evt_o
);

  localparam int CW   = $clog2(DEB_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] deb_cnt_q;
  logic          deb_q;
  logic          deb_prev_q;
  logic [RW-1:0] rep_cnt_q;
  logic          first_q;

  logic          rise;
  logic          rep_hit;
  logic [RW-1:0] rep_tgt;

  // First repeat waits the long delay, later ones use the short rate.
  assign rise    = deb_q & ~deb_prev_q;
  assign rep_tgt = first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
  assign rep_hit = deb_q & deb_prev_q & (rep_cnt_q == rep_tgt);
  assign evt_o   = rise | rep_hit;

  // Synchronise, then flip the debounced level after DEB_CYCLES differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      deb_cnt_q  <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_i};
      deb_prev_q <= deb_q;
      if (sync_q[1] != deb_q) begin
        if (deb_cnt_q == CW'(DEB_CYCLES - 1)) begin
          deb_q     <= ~deb_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + CW'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  // Count cycles since the last event while held; a release parks the timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q <= '0;
      first_q   <= 1'b0;
    end else if (rise) begin
      rep_cnt_q <= RW'(1);
      first_q   <= 1'b1;
    end else if (rep_hit) begin
      rep_cnt_q <= RW'(1);
      first_q   <= 1'b0;
    end else if (deb_q) begin
      rep_cnt_q <= rep_cnt_q + RW'(1);
    end else begin
      rep_cnt_q <= '0;
    end
  end

endmodule

// File: rtl/pwm_button_cfg_ctrl.sv
// Button front end for the PWM core: per-button event sources, pending bits,
// fixed-priority arbiter, saturating duty/divider registers and the
// valid/ack config handshake.
module pwm_button_cfg_ctrl
  import pwm_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter int DIV_W        = DIV_W_DEF,
  parameter int DUTY_STEP    = 1,
  parameter int INIT_DUTY    = 128,
  parameter int INIT_DIV     = 255,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              increase_duty_bt,
  input  logic              decrease_duty_bt,
  input  logic              increase_freq_bt,
  input  logic              decrease_freq_bt,
  input  logic              cfg_ack,
  output logic [DUTY_W-1:0] duty_cfg,
  output logic [DIV_W-1:0]  div_cfg,
  output logic              cfg_valid
);

  localparam logic [DUTY_W:0] DUTY_MAX = {1'b0, {DUTY_W{1'b1}}};
  localparam logic [DUTY_W:0] STEP     = (DUTY_W+1)'(DUTY_STEP);

  logic [NUM_BTN-1:0] btn_raw, evt, clr, pend_q, pend_d;
  cmd_e               cmd;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DUTY_W:0]    duty_ext;
  logic [DIV_W:0]     div_ext;
  logic               chg;
  state_e             state_q;
  logic               cfg_valid_q;

  assign btn_raw = {decrease_freq_bt, increase_freq_bt, decrease_duty_bt, increase_duty_bt};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_btn (
      .clk  (clk),
      .rst  (rst),
      .btn_i(btn_raw[g]),
      .evt_o(evt[g])
    );
  end

  // Pick one pending request; an opposing pair on one register cancels out.
  always_comb begin
    cmd = CMD_NONE;
    clr = '0;
    if (pend_q[BTN_DEC_DUTY] && pend_q[BTN_INC_DUTY]) begin
      clr[BTN_DEC_DUTY] = 1'b1;
      clr[BTN_INC_DUTY] = 1'b1;
    end else if (pend_q[BTN_DEC_DUTY]) begin
      cmd = CMD_DUTY_DN;
      clr[BTN_DEC_DUTY] = 1'b1;
    end else if (pend_q[BTN_INC_DUTY]) begin
      cmd = CMD_DUTY_UP;
      clr[BTN_INC_DUTY] = 1'b1;
    end else if (pend_q[BTN_DEC_FREQ] && pend_q[BTN_INC_FREQ]) begin
      clr[BTN_DEC_FREQ] = 1'b1;
      clr[BTN_INC_FREQ] = 1'b1;
    end else if (pend_q[BTN_DEC_FREQ]) begin
      cmd = CMD_FREQ_DN;
      clr[BTN_DEC_FREQ] = 1'b1;
    end else if (pend_q[BTN_INC_FREQ]) begin
      cmd = CMD_FREQ_UP;
      clr[BTN_INC_FREQ] = 1'b1;
    end
  end

  // Step in one extra bit so over/underflow is visible, then clamp.
  // The divider never reaches 0.
  always_comb begin
    duty_d   = duty_q;
    div_d    = div_q;
    duty_ext = '0;
    div_ext  = '0;
    case (cmd)
      CMD_DUTY_UP: begin
        duty_ext = {1'b0, duty_q} + STEP;
        duty_d   = (duty_ext > DUTY_MAX) ? DUTY_MAX[DUTY_W-1:0] : duty_ext[DUTY_W-1:0];
      end
      CMD_DUTY_DN: begin
        duty_ext = {1'b0, duty_q} - STEP;
        duty_d   = duty_ext[DUTY_W] ? '0 : duty_ext[DUTY_W-1:0];
      end
      CMD_FREQ_UP: begin
        div_ext = {1'b0, div_q} - (DIV_W+1)'(1);
        div_d   = (div_ext[DIV_W] || div_ext == '0) ? DIV_W'(1) : div_ext[DIV_W-1:0];
      end
      CMD_FREQ_DN: begin
        div_ext = {1'b0, div_q} + (DIV_W+1)'(1);
        div_d   = div_ext[DIV_W] ? '1 : div_ext[DIV_W-1:0];
      end
      default: ;
    endcase
  end

  // A new event wins over the clear of the same slot.
  assign pend_d = (pend_q & ~clr) | evt;
  assign chg    = (duty_d != duty_q) || (div_d != div_q);

  // Pending bits and config registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      duty_q <= DUTY_W'(INIT_DUTY);
      div_q  <= DIV_W'(INIT_DIV);
    end else begin
      pend_q <= pend_d;
      duty_q <= duty_d;
      div_q  <= div_d;
    end
  end

  // Handshake: any real change raises valid; ack drops it unless a change lands the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cfg_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (chg) begin
          state_q     <= ST_PEND;
          cfg_valid_q <= 1'b1;
        end
        ST_PEND: if (cfg_ack && !chg) begin
          state_q     <= ST_IDLE;
          cfg_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          cfg_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign duty_cfg  = duty_q;
  assign div_cfg   = div_q;
  assign cfg_valid = cfg_valid_q;

endmodule
